// File: rtl/text_buffer_ram_pkg.sv
// Shared definitions for the text buffer: character codes, the clear-sweep
// FSM state type and a width helper used for the derived port widths.
package text_buffer_ram_pkg;

    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // $clog2 clamped to at least one bit so single-row/column builds stay legal.
    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/text_buffer_ram_cursor.sv
// Cursor counters for the text buffer: keeps row, column and the linear
// address row*COLS+col as registers, so no multiplier sits on the write path.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (cursor -> 0,0)
//   clr             synchronous return to 0,0 (highest priority)
//   load            load ld_row/ld_col (caller guarantees in range)
//   advance         step one column, wrapping to the next row / to 0,0
//   lf              column 0 of the next row, last row wraps to row 0
//   linear          current linear address
module text_buffer_ram_cursor #(
    parameter int unsigned COLS   = 16,
    parameter int unsigned ROWS   = 5,
    parameter int unsigned ROW_W  = 3,
    parameter int unsigned COL_W  = 4,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              advance,
    input  logic              lf,
    input  logic [ROW_W-1:0]  ld_row,
    input  logic [COL_W-1:0]  ld_col,
    output logic [ADDR_W-1:0] linear
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row    <= '0;
            col    <= '0;
            linear <= '0;
        end else if (clr) begin
            row    <= '0;
            col    <= '0;
            linear <= '0;
        end else if (load) begin
            // Constant-coefficient product, only on the rare load path.
            row    <= ld_row;
            col    <= ld_col;
            linear <= ADDR_W'(ld_row) * ADDR_W'(COLS) + ADDR_W'(ld_col);
        end else if (advance) begin
            if (col == COL_LAST) begin
                col <= '0;
                if (row == ROW_LAST) begin
                    row    <= '0;
                    linear <= '0;
                end else begin
                    row    <= row + 1'b1;
                    linear <= linear + 1'b1;
                end
            end else begin
                col    <= col + 1'b1;
                linear <= linear + 1'b1;
            end
        end else if (lf) begin
            col <= '0;
            if (row == ROW_LAST) begin
                row    <= '0;
                linear <= '0;
            end else begin
                // Back to column 0, then down one row.
                row    <= row + 1'b1;
                linear <= linear - ADDR_W'(col) + ADDR_W'(COLS);
            end
        end
    end

endmodule

// File: rtl/text_buffer_ram.sv
// Character buffer between the host/UART writer and the font renderer.
// Holds ROWS x COLS character codes; one registered read port for video,
// one write port (addressed or cursor-driven with auto-advance and LF).
// Reset and clear_req run a hardware sweep that fills every cell with FILL_CHAR.
// Ports:
//   rd_addr/rd_data        video read, 1-cycle latency, FILL_CHAR while busy
//   wr_valid/wr_ready      write handshake, ready only when not sweeping
//   wr_mode                0 = addressed (wr_addr), 1 = cursor
//   wr_addr/wr_data        write address (mode 0) and character
//   cur_load/cur_row/cur_col  cursor load (ignored out of range or while busy)
//   cursor                 current linear cursor address
//   clear_req/busy         start fill sweep / sweep in progress
module text_buffer_ram
    import text_buffer_ram_pkg::*;
#(
    parameter int unsigned COLS      = 16,
    parameter int unsigned ROWS      = 5,
    parameter int unsigned DATA_W    = 8,
    parameter logic [DATA_W-1:0] FILL_CHAR = DATA_W'(CHAR_SPACE),
    localparam int unsigned DEPTH  = COLS * ROWS,
    localparam int unsigned ADDR_W = min1_clog2(DEPTH),
    localparam int unsigned ROW_W  = min1_clog2(ROWS),
    localparam int unsigned COL_W  = min1_clog2(COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              wr_mode,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cur_load,
    input  logic [ROW_W-1:0]  cur_row,
    input  logic [COL_W-1:0]  cur_col,
    output logic [ADDR_W-1:0] cursor,
    input  logic              clear_req,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;

    // No reset on the array so it maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              is_lf;
    logic              cur_wr;
    logic              addr_wr;
    logic              load_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign busy     = (state == CLEAR);
    assign wr_ready = !busy;
    assign accept   = wr_valid && wr_ready;
    assign is_lf    = (wr_data == DATA_W'(CHAR_LF));
    assign cur_wr   = accept && wr_mode && !is_lf;
    assign addr_wr  = accept && !wr_mode && (32'(wr_addr) < DEPTH);
    assign load_ok  = !busy && cur_load && (32'(cur_row) < ROWS) && (32'(cur_col) < COLS);

    // Single write port shared by the sweep and the host.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = FILL_CHAR;
        end else if (cur_wr) begin
            mem_we    = 1'b1;
            mem_waddr = cursor;
            mem_wdata = wr_data;
        end else if (addr_wr) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (busy) begin
            rd_data <= FILL_CHAR;
        end else if (32'(rd_addr) < DEPTH) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_ADDR) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (clear_req) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
            endcase
        end
    end

    // Clear entry wins over load and advance; a write in the same cycle still
    // uses the pre-clear cursor because the array port sees the old value.
    text_buffer_ram_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!busy && clear_req),
        .load    (load_ok),
        .advance (cur_wr),
        .lf      (accept && wr_mode && is_lf),
        .ld_row  (cur_row),
        .ld_col  (cur_col),
        .linear  (cursor)
    );

endmodule
